pipe_stage_reg: RTL and testbench

Parametrised multi-lane pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush, and a stall-cycle counter. It is the generic successor to the fixed IF/ID latch. It sits between any two CPU pipeline stages (IF/ID, ID/EX, …). Stalls propagate through backpressure rather than a global stall wire, and no accepted instruction is lost.

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline stage register with valid/ready handshake, two-entry skid buffer,
// flush, and a saturating backpressure-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned LANES         = 1,
    parameter int unsigned ZERO_ON_FLUSH = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         in_valid,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic                     in_ready,
    output logic [LANES-1:0]         out_valid,
    output logic [LANES*WIDTH-1:0]   out_data,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [1:0]               occupancy,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam int unsigned DW = LANES * WIDTH;
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [LANES-1:0] main_valid;
    logic [LANES-1:0] skid_valid;
    logic [DW-1:0]    main_data;
    logic [DW-1:0]    skid_data;

    logic in_any;
    logic out_any;
    logic in_fire;
    logic out_fire;

    // main_valid is kept all-zero whenever the stage is empty, so it drives out_valid directly.
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = 2'(state);

    // Ready depends only on state and flush, never on out_ready.
    assign in_ready = !rst && !flush && (state != TWO);
    assign in_any   = |in_valid;
    assign out_any  = |main_valid;
    assign in_fire  = in_any && in_ready;
    assign out_fire = out_any && out_ready;

    // Stage state, storage and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            main_valid   <= '0;
            skid_valid   <= '0;
            main_data    <= '0;
            skid_data    <= '0;
            stall_cycles <= '0;
        end else begin
            if (out_any && !out_ready && !flush && (stall_cycles != STALL_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end

            if (flush) begin
                state      <= EMPTY;
                main_valid <= '0;
                skid_valid <= '0;
                if (ZERO_ON_FLUSH != 0) begin
                    main_data <= '0;
                    skid_data <= '0;
                end
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            state      <= ONE;
                            main_valid <= in_valid;
                            main_data  <= in_data;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_valid <= in_valid;
                            main_data  <= in_data;
                        end else if (in_fire) begin
                            state      <= TWO;
                            skid_valid <= in_valid;
                            skid_data  <= in_data;
                        end else if (out_fire) begin
                            // Payload is held; only the valids drop.
                            state      <= EMPTY;
                            main_valid <= '0;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            state      <= ONE;
                            main_valid <= skid_valid;
                            main_data  <= skid_data;
                            skid_valid <= '0;
                        end
                    end
                    default: begin
                        state      <= EMPTY;
                        main_valid <= '0;
                        skid_valid <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (zeroing/holding flush, narrow/wide counter) share
// stimulus and are compared against a FIFO-queue reference model every cycle.
module tb_pipe_stage_reg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LANES = 2;
    localparam int unsigned DW    = WIDTH * LANES;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             flush;
    logic [LANES-1:0] in_valid;
    logic [DW-1:0]    in_data;
    logic             out_ready;

    logic             ir_z, ir_h;
    logic [LANES-1:0] ov_z, ov_h;
    logic [DW-1:0]    od_z, od_h;
    logic [1:0]       occ_z, occ_h;
    logic [2:0]       sc_z;
    logic [15:0]      sc_h;

    pipe_stage_reg #(.WIDTH(WIDTH), .LANES(LANES), .ZERO_ON_FLUSH(1), .CNT_W(3)) u_zero (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_z),
        .out_valid(ov_z), .out_data(od_z), .out_ready(out_ready), .flush(flush),
        .occupancy(occ_z), .stall_cycles(sc_z)
    );

    pipe_stage_reg #(.WIDTH(WIDTH), .LANES(LANES), .ZERO_ON_FLUSH(0), .CNT_W(16)) u_hold (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_h),
        .out_valid(ov_h), .out_data(od_h), .out_ready(out_ready), .flush(flush),
        .occupancy(occ_h), .stall_cycles(sc_h)
    );

    // Reference model: a capacity-2 FIFO of groups plus per-instance visible payload and counter.
    typedef struct packed {
        logic [LANES-1:0] v;
        logic [DW-1:0]    d;
    } grp_t;

    grp_t        q[$];
    logic [DW-1:0] last_d [2];
    int unsigned stall [2];
    int unsigned stall_max [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit ofire, ifire;
        if (rst) begin
            q.delete();
            last_d[0] = '0;
            last_d[1] = '0;
            stall[0]  = 0;
            stall[1]  = 0;
        end else if (flush) begin
            q.delete();
            last_d[0] = '0;
        end else begin
            if (q.size() > 0 && !out_ready) begin
                for (int k = 0; k < 2; k++)
                    if (stall[k] < stall_max[k]) stall[k]++;
            end
            ofire = (q.size() > 0) && out_ready;
            ifire = (|in_valid) && (q.size() < 2);
            if (ofire) void'(q.pop_front());
            if (ifire) q.push_back('{v: in_valid, d: in_data});
            if (q.size() > 0) begin
                last_d[0] = q[0].d;
                last_d[1] = q[0].d;
            end
        end
    endtask

    // One clock: check combinational ready, take the edge, then check registered outputs.
    task automatic step(output bit acc);
        logic             exp_ir;
        logic [LANES-1:0] exp_v;
        #1;
        exp_ir = !rst && !flush && (q.size() < 2);
        acc    = exp_ir && (|in_valid);
        check("in_ready_zero", 64'(ir_z), 64'(exp_ir));
        check("in_ready_hold", 64'(ir_h), 64'(exp_ir));
        @(posedge clk);
        model_update();
        @(negedge clk);
        exp_v = (q.size() > 0) ? q[0].v : '0;
        check("out_valid_zero", 64'(ov_z), 64'(exp_v));
        check("out_valid_hold", 64'(ov_h), 64'(exp_v));
        check("out_data_zero", 64'(od_z), 64'((q.size() > 0) ? q[0].d : last_d[0]));
        check("out_data_hold", 64'(od_h), 64'((q.size() > 0) ? q[0].d : last_d[1]));
        check("occupancy_zero", 64'(occ_z), 64'(q.size()));
        check("occupancy_hold", 64'(occ_h), 64'(q.size()));
        check("stall_zero", 64'(sc_z), 64'(stall[0]));
        check("stall_hold", 64'(sc_h), 64'(stall[1]));
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = '0;
        in_data  = DW'($urandom);
        for (int i = 0; i < n; i++) step(acc);
    endtask

    // Present a group until accepted, bounded so a stuck ready still ends the run.
    task automatic send(input logic [LANES-1:0] v, input logic [DW-1:0] d);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = v;
        in_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            step(acc);
            done = acc;
        end
        check("send_accepted", 64'(done), 64'(1));
        in_valid = '0;
    endtask

    initial begin
        bit acc;
        stall_max[0] = 7;
        stall_max[1] = 65535;
        last_d[0] = '0;
        last_d[1] = '0;
        stall[0]  = 0;
        stall[1]  = 0;

        // Reset held two cycles with a valid group presented.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 2'b11; in_data = 32'hDEAD_BEEF;
        step(acc);
        step(acc);
        rst = 1'b0;
        idle(1);

        // Back-to-back streaming.
        out_ready = 1'b1;
        send(2'b11, 32'hA0A0_0001);
        send(2'b11, 32'hB0B0_0002);
        send(2'b11, 32'hC0C0_0003);
        idle(2);

        // Backpressure: A in main, B in skid, C held upstream.
        out_ready = 1'b0;
        send(2'b11, 32'hA1A1_0011);
        send(2'b11, 32'hB1B1_0012);
        in_valid = 2'b11; in_data = 32'hC1C1_0013;
        for (int i = 0; i < 3; i++) step(acc);
        out_ready = 1'b1;
        send(2'b11, 32'hC1C1_0013);
        idle(3);

        // Flush while full, with a new group presented in the flush cycle.
        out_ready = 1'b0;
        send(2'b11, 32'hD2D2_0021);
        send(2'b11, 32'hE2E2_0022);
        in_valid = 2'b11; in_data = 32'hF2F2_0023; flush = 1'b1;
        step(acc);
        flush = 1'b0; in_valid = '0;
        idle(2);

        // Partial lanes, then an all-invalid group.
        out_ready = 1'b1;
        send(2'b01, 32'h1234_5678);
        idle(1);
        in_valid = 2'b00; in_data = 32'h8765_4321;
        step(acc);
        step(acc);

        // Counter saturation with a group stuck in main.
        out_ready = 1'b0;
        send(2'b10, 32'h5A5A_A5A5);
        for (int i = 0; i < 10; i++) step(acc);
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        idle(1);

        // Random traffic, flushes and occasional reset.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = LANES'($urandom_range(0, 3));
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step(acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
